// File: rtl/decoder_scan_seq_if.sv
// Control/status bundle between a scan controller and decoder_scan_seq.
// The master drives the commands; the slave (the sequencer) drives the decoder selects and status.
interface decoder_scan_seq_if;
  logic       start;
  logic       stop;
  logic       cont;
  logic [3:0] req;
  logic       a;
  logic       b;
  logic       e;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, cont, req,
    input  a, b, e, busy, done
  );

  modport slave (
    input  start, stop, cont, req,
    output a, b, e, busy, done
  );
endinterface

// File: rtl/decoder_scan_seq.sv
// Registered break-before-make scan sequencer driving a 2-to-4 enable decoder.
// Define SCAN_SKIP_IDLE_EN to skip the dwell of channels whose req bit is low.
module decoder_scan_seq #(
  parameter int unsigned DWELL_W      = 4,
  parameter int unsigned DWELL_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  decoder_scan_seq_if.slave  bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSelect = 2'd1;
  localparam logic [1:0] StDwell  = 2'd2;

  // A dwell of 0 behaves as 1; the counter runs from load value down to 0 inclusive.
  localparam int unsigned         DwellEff = (DWELL_CYCLES == 0) ? 1 : DWELL_CYCLES;
  localparam logic [DWELL_W-1:0] CntLoad  = DWELL_W'(DwellEff - 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               e_q, e_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_end;
  logic               abort;

`ifndef SCAN_SKIP_IDLE_EN
  logic unused_req;
  assign unused_req = ^bus.req;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    pass_end = 1'b0;
    abort    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          state_d = StSelect;
          ptr_d   = 2'd0;
        end
      end
      StSelect: begin
        if (bus.stop) begin
          abort = 1'b1;
`ifdef SCAN_SKIP_IDLE_EN
        end else if (!bus.req[ptr_q]) begin
          if (ptr_q != 2'd3) begin
            ptr_d = ptr_q + 2'd1;
          end else begin
            pass_end = 1'b1;
          end
`endif
        end else begin
          state_d = StDwell;
          cnt_d   = CntLoad;
        end
      end
      StDwell: begin
        if (bus.stop) begin
          abort = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (ptr_q != 2'd3) begin
          ptr_d   = ptr_q + 2'd1;
          state_d = StSelect;
        end else begin
          pass_end = 1'b1;
        end
      end
      default: begin
        abort = 1'b1;
      end
    endcase

    if (abort) begin
      state_d = StIdle;
      ptr_d   = 2'd0;
    end

    if (pass_end) begin
      done_d  = 1'b1;
      ptr_d   = 2'd0;
      state_d = bus.cont ? StSelect : StIdle;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    a_d    = (state_d != StIdle) ? ptr_d[1] : 1'b0;
    b_d    = (state_d != StIdle) ? ptr_d[0] : 1'b0;
    e_d    = (state_d == StDwell);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a    = a_q;
  assign bus.b    = b_q;
  assign bus.e    = e_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: per-pass schedule model checked every cycle, plus literal checks.
module tb_decoder_scan_seq;

`ifdef SCAN_SKIP_IDLE_EN
  localparam int unsigned D = 2;
  localparam logic [3:0] ReqFull = 4'hF;
`else
  localparam int unsigned D = 4;
  localparam logic [3:0] ReqFull = 4'b1010;  // must be ignored in this build
`endif
  localparam int unsigned P  = D + 1;
  localparam int unsigned DE = (D == 0) ? 1 : D;

  logic clk = 1'b0;
  logic rst;
  decoder_scan_seq_if bus ();

  decoder_scan_seq #(
    .DWELL_W     (4),
    .DWELL_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cur   = 0;

  // Model: each pass is a list of per-cycle {a,b,e}; busy while the list is non-empty.
  logic [2:0] sched[$];
  logic       m_done;

  task automatic build_pass();
    for (int k = 0; k < 4; k++) begin
      logic skip;
      skip = 1'b0;
`ifdef SCAN_SKIP_IDLE_EN
      skip = !bus.req[k];
`endif
      sched.push_back({2'(k), 1'b0});
      if (!skip) begin
        for (int j = 0; j < int'(DE); j++) sched.push_back({2'(k), 1'b1});
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sched.delete();
      m_done <= 1'b0;
    end else if (sched.size() == 0) begin
      m_done <= 1'b0;
      if (bus.start && !bus.stop) build_pass();
    end else if (bus.stop) begin
      sched.delete();
      m_done <= 1'b0;
    end else begin
      void'(sched.pop_front());
      if (sched.size() == 0) begin
        m_done <= 1'b1;
        if (bus.cont) build_pass();
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got {a,b,e,busy,done}=%b expected %b", name, $time, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.a, bus.b, bus.e, bus.busy, bus.done};
  endfunction

  always @(negedge clk) begin
    logic [2:0] ex;
    ex = (sched.size() != 0) ? sched[0] : 3'b000;
    check("model", outs(), {ex, sched.size() != 0, m_done});
  end

  task automatic at_cycle(input int n);
    repeat (n - cur) @(negedge clk);
    cur = n;
  endtask

  // Called at a negedge; start is sampled at the next edge (C0) and cycle 1 follows.
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cur = 1;
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.cont  = 1'b0;
    bus.req   = ReqFull;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", outs(), 5'b00000);

    // Single pass, with a stray start during channel 0 dwell.
    pulse_start();
    at_cycle(1);
    check("ch0_select", outs(), 5'b00010);
    at_cycle(3);
    check("ch0_dwell", outs(), 5'b00110);
    bus.start = 1'b1;
    at_cycle(4);
    bus.start = 1'b0;
    at_cycle(1 + P);
    check("ch1_select_gap", outs(), 5'b01010);
    at_cycle(2 + P);
    check("ch1_dwell", outs(), 5'b01110);
    at_cycle(2 + 3 * P);
    check("ch3_dwell", outs(), 5'b11110);
    at_cycle(4 * P + 1);
    check("single_done", outs(), 5'b00001);
    repeat (2) @(negedge clk);

    // Continuous mode, dropped mid second pass.
    bus.req  = 4'hF;
    bus.cont = 1'b1;
    pulse_start();
    at_cycle(4 * P + 1);
    check("cont_wrap", outs(), 5'b00011);
    at_cycle(6 * P);
    bus.cont = 1'b0;
    at_cycle(8 * P + 1);
    check("cont_end", outs(), 5'b00001);
    repeat (2) @(negedge clk);

    // Abort during channel 1 dwell, then immediate restart.
    pulse_start();
    at_cycle(P + 3);
    bus.stop = 1'b1;
    at_cycle(P + 4);
    bus.stop = 1'b0;
    check("stop_idle", outs(), 5'b00000);
    bus.start = 1'b1;
    at_cycle(P + 5);
    bus.start = 1'b0;
    check("restart", outs(), 5'b00010);
    repeat (4 * P + 3) @(negedge clk);

    // start and stop together in idle.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("start_stop_idle", outs(), 5'b00000);
    @(negedge clk);

    // Asynchronous reset during channel 2 dwell.
    pulse_start();
    at_cycle(2 * P + 3);
    check("pre_reset_ch2", outs(), 5'b10110);
    #1 rst = 1'b1;
    #1 check("async_reset", outs(), 5'b00000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", outs(), 5'b00000);

`ifdef SCAN_SKIP_IDLE_EN
    bus.req = 4'b1010;
    pulse_start();
    at_cycle(1);
    check("skip_ch0", outs(), 5'b00010);
    at_cycle(2);
    check("skip_ch1_sel", outs(), 5'b01010);
    at_cycle(3);
    check("skip_ch1_dwell", outs(), 5'b01110);
    at_cycle(5);
    check("skip_ch2", outs(), 5'b10010);
    at_cycle(9);
    check("skip_done", outs(), 5'b00001);
    repeat (2) @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
# decoder_scan_seq

Registered scan sequencer that sits directly upstream of the 2-to-4 enable decoder and drives its select pair `a`/`b` and enable `e`. It steps through the four decoder outputs in order and holds each one enabled for a programmable dwell time. Between channels it inserts one disabled cycle so the decoder never switches outputs while enabled (break-before-make). It supports single-pass and continuous scanning, immediate abort, and an optional skip of unrequested channels.

## Interface
- `DWELL_W`, 4: width of the dwell counter.
- `DWELL_CYCLES`, 4: cycles `e` stays high per channel; legal range 1..2^DWELL_W-1; a value of 0 is treated as 1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a pass; sampled only in IDLE.
- `stop` in 1: abort the scan; sampled in every non-IDLE state.
- `cont` in 1: continuous mode; sampled at the end of each pass.
- `req` in 4: per-channel request; `req[k]` corresponds to select value k. Used only when SCAN_SKIP_IDLE_EN is defined.
- `a` out 1: select MSB (sel[1]) to the decoder.
- `b` out 1: select LSB (sel[0]) to the decoder.
- `e` out 1: decoder enable.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at the end of each completed pass.

## Operation
- State machine states: IDLE, SELECT, DWELL.
- Internal state: a 2-bit pointer `ptr` and a dwell counter `cnt` of width DWELL_W.
- All outputs are registered. Reset values: `a`=0, `b`=0, `e`=0, `busy`=0, `done`=0; `ptr`=0, `cnt`=0, state=IDLE.
- IDLE:
  - `e`=0 and `{a,b}`=00.
  - `start`=1 with `stop`=0: go to SELECT with `ptr`=0.
  - `start` and `stop` both high: stop wins; remain in IDLE.
- SELECT (one cycle per channel):
  - `{a,b}` = `ptr` and `e`=0.
  - Next state is DWELL, with `cnt` loaded to DWELL_CYCLES-1.
- DWELL:
  - `{a,b}` holds `ptr` and `e`=1.
  - While `cnt`≠0, decrement `cnt` each cycle.
  - When `cnt`=0 and `ptr`<3: increment `ptr` and go to SELECT.
  - When `cnt`=0 and `ptr`=3 (end of pass): pulse `done` for one cycle.
    - If `cont`=1: set `ptr`=0 (wrap-around) and go to SELECT.
    - If `cont`=0: go to IDLE.
- `stop`=1 in SELECT or DWELL: next cycle state=IDLE, `e`=0, `{a,b}`=00, `ptr`=0, and no `done` pulse. `stop` takes priority over end-of-pass.
- `start` while busy: ignored.
- `req` has no effect unless the macro below is defined.
- Reset asserted mid-scan: all outputs go to their reset values immediately without waiting for a clock edge. After `rst` deasserts, the block waits for a new `start`.

## Timing
- Let C0 be the edge at which `start` is sampled in IDLE, and D = DWELL_CYCLES.
- Channel k (0..3):
  - SELECT occupies cycle 1+k(D+1).
  - DWELL occupies cycles 2+k(D+1) through 1+k(D+1)+D.
- Channel period is D+1 cycles. A full pass is 4(D+1) cycles.
- `done` and `busy` in the cycle after the last DWELL cycle of channel 3, i.e. cycle 4(D+1)+1:
  - `done`=1 in that cycle.
  - If `cont`=0: `busy`=0 in that same cycle.
  - If `cont`=1: that cycle is SELECT for channel 0, with `busy`=1.
- Latency from `stop` sampled to `e`=0 is one cycle.
- `e` never rises in the same cycle that `{a,b}` changes.

## Configuration
- Macro: `SCAN_SKIP_IDLE_EN`.
- Undefined: every channel 0..3 is serviced every pass and `req` is ignored.
- Defined:
  - In SELECT, if `req[ptr]`=0, the block skips DWELL. `e` stays 0 for that cycle.
  - If `ptr`<3, `ptr` increments and the state remains SELECT. If `ptr`=3, end-of-pass handling applies (`done` pulse, then `cont` decides between SELECT and IDLE).
  - A skipped channel costs exactly one cycle.
  - `req` is sampled in SELECT only; deasserting `req` during DWELL does not shorten the dwell.

## Test plan
- D=4, `cont`=0, pulse `start`:
  - `e` high in cycles 2-5 with `ab`=00, 7-10 with `ab`=01, 12-15 with `ab`=10, 17-20 with `ab`=11.
  - `e` low in cycles 6, 11 and 16.
  - `done`=1 and `busy`=0 in cycle 21.
- D=4, `cont`=1: cycle 21 has `done`=1, `busy`=1, `ab`=00, `e`=0. The second pass repeats with a 20-cycle period. Deasserting `cont` before cycle 41 ends the scan with `busy`=0 in cycle 41.
- `stop` asserted in cycle 8 (channel 1 DWELL): cycle 9 has `e`=0, `ab`=00, `busy`=0, and `done` never pulses. A `start` in cycle 9 is accepted.
- `start` and `stop` asserted together in IDLE: block stays IDLE and `busy` stays 0. `start` during DWELL has no effect on the timing above.
- `rst` asserted asynchronously mid-DWELL of channel 2: `e`, `a`, `b`, `busy` and `done` go to 0 before the next edge, and the block stays IDLE after release.
- With `SCAN_SKIP_IDLE_EN` defined, D=2, `req`=4'b1010:
  - Only channels 1 and 3 get `e`=1.
  - Channels 0 and 2 each consume one SELECT cycle with `e`=0.
  - A pass lasts 1+3+1+3 = 8 cycles, and `done` occurs in cycle 9.
